// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus: opcodes, nibble modes, geometry.
package lcd_pkg;
    // Display geometry, shared with the write controller
    localparam int         LCD_LINE_LEN   = 16;
    localparam logic [6:0] LCD_LINE2_BASE = 7'h40;
    localparam int         BUF_DEPTH      = 2 * LCD_LINE_LEN;
    localparam int         BUF_AW         = $clog2(BUF_DEPTH);

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    // Command opcodes: the highest set bit identifies the instruction
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_DISP  = 8'h08;
    localparam logic [7:0] CMD_FUNC  = 8'h20;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    typedef enum logic [1:0] {INIT8, NIB_HI, NIB_LO} mode_e;
    typedef enum logic       {TGT_DDRAM, TGT_CGRAM} target_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } bus_byte_t;

    // True when b belongs to opcode op: b's leading one is op's single bit
    function automatic logic cmd_is(input logic [7:0] b, input logic [7:0] op);
        return (b & ~(op - 8'd1)) == op;
    endfunction
endpackage

// File: rtl/lcd_bus_rx_if.sv
// 4-bit LCD bus pins; master is the write controller, slave is the responder.
interface lcd_bus_rx_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [3:0] sf_d_in;
    logic [3:0] sf_d_out;
    logic       sf_d_oe;

    modport master (output lcd_rs, lcd_rw, lcd_e, sf_d_in, input sf_d_out, sf_d_oe);
    modport slave  (input lcd_rs, lcd_rw, lcd_e, sf_d_in, output sf_d_out, sf_d_oe);
endinterface

// File: rtl/lcd_charbuf.sv
// 32x8 character mirror: one write port (data or clear), one registered read port.
module lcd_charbuf
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [BUF_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [BUF_AW-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem [BUF_DEPTH];
    logic [7:0] rdata_d, rdata_q;

    // Storage array; contents are defined by the auto-clear after reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read mux feeding the output register
    always_comb begin
        rdata_d = mem[raddr];
    end

    // One-cycle registered read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/lcd_bus_rx.sv
// HD44780-style 4-bit bus responder: decodes E-strobed nibbles, mirrors DDRAM
// into a 32-byte buffer and answers busy-flag/address reads.
module lcd_bus_rx
    import lcd_pkg::*;
#(
    parameter logic [6:0] LINE2_BASE = LCD_LINE2_BASE,
    parameter int         LINE_LEN   = LCD_LINE_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_bus_rx_if.slave       bus,
    input  logic [BUF_AW-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              byte_valid,
    output logic              byte_rs,
    output logic [7:0]        byte_data,
    output logic [6:0]        ac,
    output logic              four_bit_mode,
    output logic              display_on,
    output logic              busy,
    output logic              overrun
);
    logic [1:0]      e_sync_q, rs_sync_q, rw_sync_q;
    logic [1:0][3:0] d_sync_q;
    logic            e_prev_q;
    logic            e_s, rs_s, rw_s, e_fall;
    logic [3:0]      d_s;

    mode_e       mode_d, mode_q;
    target_e     tgt_d, tgt_q;
    logic [3:0]  hi_d, hi_q;
    logic [6:0]  ac_d, ac_q;
    logic        id_d, id_q, disp_d, disp_q, four_d, four_q;
    logic        busy_d, busy_q, pend_clr_d, pend_clr_q, overrun_d, overrun_q;
    logic [BUF_AW-1:0] clr_idx_d, clr_idx_q;
    logic        bv_d, bv_q, brs_d, brs_q;
    logic [7:0]  bdata_d, bdata_q;

    bus_byte_t   cur;
    logic        byte_done, do_cmd, do_data, map_ok, rd_en;
    logic [6:0]  line2_off;
    logic [BUF_AW-1:0] map_idx;
    logic        buf_we;
    logic [BUF_AW-1:0] buf_waddr;
    logic [7:0]  buf_wdata;

    // Two-flop synchronizers plus an E history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_sync_q  <= '0;
            rs_sync_q <= '0;
            rw_sync_q <= '0;
            d_sync_q  <= '0;
            e_prev_q  <= 1'b0;
        end else begin
            e_sync_q  <= {e_sync_q[0], bus.lcd_e};
            rs_sync_q <= {rs_sync_q[0], bus.lcd_rs};
            rw_sync_q <= {rw_sync_q[0], bus.lcd_rw};
            d_sync_q  <= {d_sync_q[0], bus.sf_d_in};
            e_prev_q  <= e_sync_q[1];
        end
    end

    assign e_s    = e_sync_q[1];
    assign rs_s   = rs_sync_q[1];
    assign rw_s   = rw_sync_q[1];
    assign d_s    = d_sync_q[1];
    assign e_fall = e_prev_q & ~e_s;

    // DDRAM address to buffer index; holes between the lines are unmapped
    always_comb begin
        line2_off = ac_q - LINE2_BASE;
        map_ok    = 1'b0;
        map_idx   = ac_q[BUF_AW-1:0];
        if (ac_q < 7'(LINE_LEN)) begin
            map_ok = 1'b1;
        end else if (ac_q >= LINE2_BASE && line2_off < 7'(LINE_LEN)) begin
            map_ok  = 1'b1;
            map_idx = BUF_AW'(LINE_LEN) + line2_off[BUF_AW-1:0];
        end
    end

    // Nibble assembly, command/data execution and the clear sequencer
    always_comb begin
        mode_d     = mode_q;
        tgt_d      = tgt_q;
        hi_d       = hi_q;
        ac_d       = ac_q;
        id_d       = id_q;
        disp_d     = disp_q;
        four_d     = four_q;
        busy_d     = busy_q;
        pend_clr_d = pend_clr_q;
        clr_idx_d  = clr_idx_q;
        overrun_d  = overrun_q;
        bv_d       = 1'b0;
        brs_d      = brs_q;
        bdata_d    = bdata_q;
        buf_we     = 1'b0;
        buf_waddr  = clr_idx_q;
        buf_wdata  = CHAR_SPACE;
        byte_done  = 1'b0;
        cur        = '0;
        do_cmd     = 1'b0;
        do_data    = 1'b0;

        case (mode_q)
            INIT8: if (e_fall && !rw_s) begin
                byte_done = 1'b1;
                cur       = '{rs: rs_s, data: {d_s, 4'h0}};
            end
            NIB_HI: if (e_fall) begin
                hi_d   = d_s;
                mode_d = NIB_LO;
            end
            NIB_LO: if (e_fall) begin
                // Reads also advance the phase so the pair stays aligned
                mode_d = NIB_HI;
                if (!rw_s) begin
                    byte_done = 1'b1;
                    cur       = '{rs: rs_s, data: {hi_q, d_s}};
                end
            end
            default: mode_d = INIT8;
        endcase

        if (byte_done) begin
            if (busy_q) begin
                overrun_d = 1'b1;
            end else if (mode_q == INIT8) begin
                // 8-bit strobes carry only the upper nibble; 0x2 drops to 4-bit
                if (!cur.rs) begin
                    if (cur.data == CMD_FUNC) begin
                        four_d = 1'b1;
                        mode_d = NIB_HI;
                    end else begin
                        do_cmd = 1'b1;
                    end
                end
            end else begin
                bv_d    = 1'b1;
                brs_d   = cur.rs;
                bdata_d = cur.data;
                do_cmd  = !cur.rs;
                do_data = cur.rs;
            end
        end

        if (do_cmd) begin
            if (cmd_is(cur.data, CMD_DDRAM)) begin
                ac_d  = cur.data[6:0];
                tgt_d = TGT_DDRAM;
            end else if (cmd_is(cur.data, CMD_CGRAM)) begin
                tgt_d = TGT_CGRAM;
            end else if (cmd_is(cur.data, CMD_FUNC)) begin
                // function set: width is already fixed, nothing to do
            end else if (cmd_is(cur.data, CMD_DISP)) begin
                disp_d = cur.data[2];
            end else if (cmd_is(cur.data, CMD_ENTRY)) begin
                id_d = cur.data[1];
            end else if (cmd_is(cur.data, CMD_HOME)) begin
                ac_d = '0;
            end else if (cmd_is(cur.data, CMD_CLEAR)) begin
                busy_d    = 1'b1;
                clr_idx_d = '0;
            end
        end

        // CGRAM data is swallowed without moving the address counter
        if (do_data && tgt_q == TGT_DDRAM) begin
            if (map_ok) begin
                buf_we    = 1'b1;
                buf_waddr = map_idx;
                buf_wdata = cur.data;
            end
            ac_d = id_q ? ac_q + 7'd1 : ac_q - 7'd1;
        end

        if (pend_clr_q) begin
            pend_clr_d = 1'b0;
            busy_d     = 1'b1;
            clr_idx_d  = '0;
        end

        // Clear owns the write port while busy
        if (busy_q) begin
            buf_we    = 1'b1;
            buf_waddr = clr_idx_q;
            buf_wdata = CHAR_SPACE;
            if (clr_idx_q == BUF_AW'(BUF_DEPTH - 1)) begin
                busy_d = 1'b0;
                ac_d   = '0;
                id_d   = 1'b1;
            end else begin
                clr_idx_d = clr_idx_q + 1'b1;
            end
        end
    end

    // State register; reset arms the power-on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= INIT8;
            tgt_q      <= TGT_DDRAM;
            hi_q       <= '0;
            ac_q       <= '0;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            four_q     <= 1'b0;
            busy_q     <= 1'b0;
            pend_clr_q <= 1'b1;
            clr_idx_q  <= '0;
            overrun_q  <= 1'b0;
            bv_q       <= 1'b0;
            brs_q      <= 1'b0;
            bdata_q    <= '0;
        end else begin
            mode_q     <= mode_d;
            tgt_q      <= tgt_d;
            hi_q       <= hi_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            disp_q     <= disp_d;
            four_q     <= four_d;
            busy_q     <= busy_d;
            pend_clr_q <= pend_clr_d;
            clr_idx_q  <= clr_idx_d;
            overrun_q  <= overrun_d;
            bv_q       <= bv_d;
            brs_q      <= brs_d;
            bdata_q    <= bdata_d;
        end
    end

    // Read-back drive: busy flag and address counter, nibble by nibble
    always_comb begin
        rd_en        = e_s && rw_s && (mode_q != INIT8);
        bus.sf_d_oe  = rd_en;
        bus.sf_d_out = 4'h0;
        if (rd_en && !rs_s) begin
            bus.sf_d_out = (mode_q == NIB_HI) ? {busy_q, ac_q[6:4]} : ac_q[3:0];
        end
    end

    lcd_charbuf u_charbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (buf_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign byte_valid    = bv_q;
    assign byte_rs       = brs_q;
    assign byte_data     = bdata_q;
    assign ac            = ac_q;
    assign four_bit_mode = four_q;
    assign display_on    = disp_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_lcd_bus_rx.sv
// Bench for lcd_bus_rx: bus-level stimulus, byte scoreboard, buffer readback.
module tb_lcd_bus_rx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       byte_valid, byte_rs;
    logic [7:0] byte_data;
    logic [6:0] ac;
    logic       four_bit_mode, display_on, busy, overrun;

    int compared = 0;
    int mism = 0;
    int busy_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    lcd_bus_rx_if bus ();

    lcd_bus_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .byte_valid    (byte_valid),
        .byte_rs       (byte_rs),
        .byte_data     (byte_data),
        .ac            (ac),
        .four_bit_mode (four_bit_mode),
        .display_on    (display_on),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #10 clk = ~clk;

    // Capture accepted bytes and total busy cycles
    always @(negedge clk) begin
        if (rst_n && byte_valid) obs_q.push_back({byte_rs, byte_data});
        if (busy) busy_cnt++;
    end

    task automatic nib(input logic rs, input logic rw, input logic [3:0] d);
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.sf_d_in = d;
        repeat (2) @(negedge clk);
        bus.lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic rd_nib(input logic rs, output logic [3:0] d, output logic oe);
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_rw = 1'b1;
        repeat (2) @(negedge clk);
        bus.lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        d = bus.sf_d_out; oe = bus.sf_d_oe;
        @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wr_byte(input logic rs, input logic [7:0] b, input bit accept);
        if (accept) exp_q.push_back({rs, b});
        nib(rs, 1'b0, b[7:4]);
        nib(rs, 1'b0, b[3:0]);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        compared++;
        if (busy) begin mism++; $display("FAIL %s_busy_timeout: busy still %b", name, busy); end
    endtask

    task automatic test_reset();
        int first, cnt;
        logic [7:0] got;
        rst_n = 1'b0; rd_addr = '0;
        bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.sf_d_in = 4'h0;
        repeat (3) @(negedge clk);
        compared++;
        if ({byte_valid, byte_rs, byte_data, ac, four_bit_mode, display_on, busy, overrun,
             bus.sf_d_oe, bus.sf_d_out} !== '0) begin
            mism++;
            $display("FAIL reset_outputs: ac=%h busy=%b oe=%b bv=%b want all 0", ac, busy, bus.sf_d_oe, byte_valid);
        end
        rst_n = 1'b1;
        first = 0; cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) begin cnt++; if (first == 0) first = c; end
        end
        compared++;
        if (first != 1 || cnt != 32) begin
            mism++; $display("FAIL reset_busy: first=%0d count=%0d want 1/32", first, cnt);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); rd_addr = 5'(i);
            @(negedge clk); got = rd_data;
            compared++;
            if (got !== 8'h20) begin mism++; $display("FAIL reset_buf[%0d]: got %h want 20", i, got); end
        end
    endtask

    task automatic test_init();
        logic [3:0] d; logic oe; logic [8:0] e, g; int b0;
        rd_nib(1'b0, d, oe);
        compared++;
        if (oe !== 1'b0) begin mism++; $display("FAIL init8_read_oe: got %b want 0", oe); end
        nib(0, 0, 4'h3); nib(0, 0, 4'h3); nib(0, 0, 4'h3);
        compared++;
        if (four_bit_mode !== 1'b0) begin mism++; $display("FAIL init_pre_mode: got %b want 0", four_bit_mode); end
        nib(0, 0, 4'h2);
        compared++;
        if (four_bit_mode !== 1'b1) begin mism++; $display("FAIL init_mode: got %b want 1", four_bit_mode); end
        wr_byte(0, 8'h28, 1); wr_byte(0, 8'h06, 1); wr_byte(0, 8'h0C, 1);
        b0 = busy_cnt;
        wr_byte(0, 8'h01, 1);
        wait_idle("init_clear");
        compared++;
        if (busy_cnt - b0 != 32) begin mism++; $display("FAIL init_clear_len: got %0d want 32", busy_cnt - b0); end
        compared++;
        if (display_on !== 1'b1) begin mism++; $display("FAIL init_display_on: got %b want 1", display_on); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = 'x;
            if (obs_q.size() != 0) g = obs_q.pop_front();
            compared++;
            if (g !== e) begin mism++; $display("FAIL init_byte: got %h want %h", g, e); end
        end
        compared++;
        if (obs_q.size() != 0) begin mism++; $display("FAIL init_extra_bytes: got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_write_hi();
        logic [8:0] e, g;
        wr_byte(0, 8'h80, 1); wr_byte(1, 8'h48, 1); wr_byte(1, 8'h69, 1);
        compared++;
        if (ac !== 7'h02) begin mism++; $display("FAIL hi_ac: got %h want 02", ac); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rd_addr = 5'(i);
            @(negedge clk);
            compared++;
            if (rd_data !== (i == 0 ? 8'h48 : 8'h69)) begin
                mism++; $display("FAIL hi_buf[%0d]: got %h want %h", i, rd_data, (i == 0 ? 8'h48 : 8'h69));
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = 'x;
            if (obs_q.size() != 0) g = obs_q.pop_front();
            compared++;
            if (g !== e) begin mism++; $display("FAIL hi_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_line2();
        logic [7:0] want; logic [8:0] e, g;
        wr_byte(0, 8'hC0, 1);
        for (int i = 0; i < 17; i++) wr_byte(1, 8'(8'h41 + i), 1);
        compared++;
        if (ac !== 7'h51) begin mism++; $display("FAIL line2_ac: got %h want 51", ac); end
        for (int i = 0; i < 18; i++) begin
            // index 16..31 hold the line, then buf[0] and buf[2] must be untouched
            @(negedge clk); rd_addr = (i < 16) ? 5'(16 + i) : (i == 16 ? 5'd0 : 5'd2);
            want = (i < 16) ? 8'(8'h41 + i) : (i == 16 ? 8'h48 : 8'h20);
            @(negedge clk);
            compared++;
            if (rd_data !== want) begin mism++; $display("FAIL line2_buf[%0d]: got %h want %h", rd_addr, rd_data, want); end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = 'x;
            if (obs_q.size() != 0) g = obs_q.pop_front();
            compared++;
            if (g !== e) begin mism++; $display("FAIL line2_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_reverse_read();
        logic [3:0] dh, dl; logic oh, ol; logic [8:0] e, g;
        wr_byte(0, 8'hCF, 1); wr_byte(0, 8'h04, 1); wr_byte(1, 8'h5A, 1); wr_byte(1, 8'h5B, 1);
        compared++;
        if (ac !== 7'h4D) begin mism++; $display("FAIL rev_ac: got %h want 4d", ac); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rd_addr = 5'(31 - i);
            @(negedge clk);
            compared++;
            if (rd_data !== (i == 0 ? 8'h5A : 8'h5B)) begin
                mism++; $display("FAIL rev_buf[%0d]: got %h want %h", 31 - i, rd_data, (i == 0 ? 8'h5A : 8'h5B));
            end
        end
        rd_nib(1'b0, dh, oh); rd_nib(1'b0, dl, ol);
        compared++;
        if ({oh, dh, ol, dl} !== {1'b1, 4'h4, 1'b1, 4'hD}) begin
            mism++; $display("FAIL rd_ac_pair: got oe%b %h oe%b %h want oe1 4 oe1 d", oh, dh, ol, dl);
        end
        rd_nib(1'b1, dh, oh); rd_nib(1'b1, dl, ol);
        compared++;
        if ({oh, dh, ol, dl, ac} !== {1'b1, 4'h0, 1'b1, 4'h0, 7'h4D}) begin
            mism++; $display("FAIL rd_data_pair: got %h %h ac=%h want 0 0 ac=4d", dh, dl, ac);
        end
        compared++;
        if (bus.sf_d_oe !== 1'b0) begin mism++; $display("FAIL rd_oe_idle: got %b want 0", bus.sf_d_oe); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = 'x;
            if (obs_q.size() != 0) g = obs_q.pop_front();
            compared++;
            if (g !== e) begin mism++; $display("FAIL rev_byte: got %h want %h", g, e); end
        end
        compared++;
        if (obs_q.size() != 0) begin mism++; $display("FAIL rd_extra_bytes: got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_wrap_cgram();
        logic [8:0] e, g;
        wr_byte(0, 8'h06, 1); wr_byte(0, 8'hFF, 1);
        compared++;
        if (ac !== 7'h7F) begin mism++; $display("FAIL wrap_set: got %h want 7f", ac); end
        wr_byte(1, 8'h33, 1);
        compared++;
        if (ac !== 7'h00) begin mism++; $display("FAIL wrap_ac: got %h want 00", ac); end
        wr_byte(0, 8'h40, 1); wr_byte(1, 8'h77, 1);
        compared++;
        if (ac !== 7'h00) begin mism++; $display("FAIL cgram_ac: got %h want 00", ac); end
        @(negedge clk); rd_addr = 5'd0;
        @(negedge clk);
        compared++;
        if (rd_data !== 8'h48) begin mism++; $display("FAIL cgram_buf0: got %h want 48", rd_data); end
        wr_byte(0, 8'h80, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = 'x;
            if (obs_q.size() != 0) g = obs_q.pop_front();
            compared++;
            if (g !== e) begin mism++; $display("FAIL wrap_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_back_to_back_overrun();
        logic [8:0] e, g;
        compared++;
        if (overrun !== 1'b0) begin mism++; $display("FAIL ovr_pre: got %b want 0", overrun); end
        wr_byte(0, 8'h01, 1);
        wr_byte(1, 8'h41, 0);
        wait_idle("ovr_clear");
        compared++;
        if ({overrun, ac} !== {1'b1, 7'h00}) begin mism++; $display("FAIL ovr_flag: got ovr=%b ac=%h want 1/00", overrun, ac); end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); rd_addr = 5'(i);
            @(negedge clk);
            compared++;
            if (rd_data !== 8'h20) begin mism++; $display("FAIL ovr_buf[%0d]: got %h want 20", i, rd_data); end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = 'x;
            if (obs_q.size() != 0) g = obs_q.pop_front();
            compared++;
            if (g !== e) begin mism++; $display("FAIL ovr_byte: got %h want %h", g, e); end
        end
        compared++;
        if (obs_q.size() != 0) begin mism++; $display("FAIL ovr_dropped_byte: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_hi();
        test_line2();
        test_reverse_read();
        test_wrap_cgram();
        test_back_to_back_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule

// File: doc/lcd_bus_rx.md
Name: lcd_bus_rx

Overview:
- Responder/receiver end of the HD44780-style 4-bit character-LCD bus (lcd_rs, lcd_rw, lcd_e, sf_d[11:8]) driven by the existing LCD write controller.
- Decodes E-strobed nibbles into commands and data, mirrors the 2x16 display into a 32-byte character buffer, and answers busy-flag/address reads.
- Used as an on-chip loopback monitor and as the bus model for LCD regression.

Parameters:
- LINE2_BASE, 7'h40, DDRAM address mapped to buffer index 16.
- LINE_LEN, 16, characters per line; buffer depth is 2*LINE_LEN = 32.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- lcd_rs  in  1  register select from the bus (0 = command, 1 = data).
- lcd_rw  in  1  1 = read from this block, 0 = write to this block.
- lcd_e  in  1  enable strobe.
- sf_d_in  in  4  bus data nibble.
- sf_d_out  out  4  read-back nibble.
- sf_d_oe  out  1  output enable for sf_d_out.
- rd_addr  in  5  character buffer read address.
- rd_data  out  8  buffer byte at rd_addr, registered, 1-cycle latency.
- byte_valid  out  1  one-cycle pulse when a write byte is accepted.
- byte_rs  out  1  rs of the accepted byte.
- byte_data  out  8  accepted byte.
- ac  out  7  DDRAM address counter.
- four_bit_mode  out  1  interface has switched to 4-bit mode.
- display_on  out  1  D bit of the last display-control command.
- busy  out  1  internal operation (clear) in progress.
- overrun  out  1  sticky: a write byte completed while busy.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0 except sf_d_oe=0 and ac=0.
  - Mode returns to INIT8, nibble phase to HI, I/D=1, target=DDRAM.
  - An auto-clear starts on the first clk after rst_n rises (busy=1 for 32 cycles, buffer filled with 8'h20).
  - Reset mid-byte discards the partial byte.
- Input sync and sampling:
  - lcd_e, lcd_rs, lcd_rw and sf_d_in pass through 2-flop synchronizers.
  - A write nibble is sampled on the synchronized falling edge of E with rw=0, using the rs/d values registered in that same cycle.
- Mode state machine INIT8 -> NIB_HI <-> NIB_LO:
  - INIT8: each write strobe is a whole 8-bit command = {nibble, 4'h0}.
  - 0x3 nibbles in INIT8 are ignored.
  - Nibble 0x2 in INIT8 sets four_bit_mode=1 and moves to NIB_HI. No byte_valid is produced for INIT8 strobes.
  - NIB_HI: latch the high nibble, go to NIB_LO.
  - NIB_LO: form the byte {hi, lo}, go to NIB_HI.
  - byte_valid pulses 1 cycle after the falling edge that completes the byte.
  - An rs change between the HI and LO nibbles: the byte takes the LO nibble's rs.
- Command decode (rs=0), priority from MSB:
  - 1xxxxxxx: ac = byte[6:0], target = DDRAM.
  - 01xxxxxx: target = CGRAM; subsequent data writes are discarded, ac unchanged.
  - 001xxxxx: function set, ignored; the block stays in 4-bit mode.
  - 00001DCB: display_on = D.
  - 000001IS: I/D = I (S ignored).
  - 0000001x: ac = 0.
  - 00000001: clear.
    - busy=1 for exactly 32 cycles; index 0..31 is written with 8'h20, one per cycle.
    - ac=0 and I/D=1 at the end.
- Data write (rs=1, target DDRAM):
  - ac 0x00-0x0F maps to index ac; LINE2_BASE..LINE2_BASE+15 maps to index 16 + (ac - LINE2_BASE).
  - Other addresses: no buffer write.
  - ac then increments (I/D=1) or decrements (I/D=0) modulo 128, so 0x7F+1 = 0x00.
- While busy: a completed write byte is dropped (no byte_valid, no state change), and overrun is set. overrun clears only on reset.
- Reads (rw=1), 4-bit mode only:
  - sf_d_oe=1 while synchronized E=1 and rw=1.
  - rs=0: HI phase returns {busy, ac[6:4]}, LO phase returns ac[3:0].
  - rs=1: returns 4'h0, ac unchanged.
  - The falling edge of E advances the nibble phase exactly as a write does.
  - Reads in INIT8 leave sf_d_oe=0.
- Buffer access:
  - The clear port has priority over a data write in the same cycle; this cannot occur given the busy drop.
  - The rd_addr port is independent of both.

Decomposition:
- Shared package lcd_pkg holds:
  - command opcode masks (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISP, CMD_FUNC, CMD_CGRAM, CMD_DDRAM);
  - mode encoding (INIT8, NIB_HI, NIB_LO);
  - the constant 8'h20;
  - LCD line geometry, shared with the write controller.
- One sub-module lcd_charbuf: 32x8 memory with one write port (data or clear) and a registered read port.

Test Plan:
- Reset then idle 40 cycles -> busy high cycles 1..32, then 0. rd_addr=0..31 all read 8'h20.
- Init nibbles 3,3,3,2 -> four_bit_mode=1 after the 4th strobe, no byte_valid.
- Then command 0x28,0x06,0x0C,0x01 as nibble pairs -> byte_valid x4 with byte_data 28,06,0C,01; display_on=1; busy for 32 cycles.
- After init: 0x80 then data 'H','i' -> buf[0]=0x48, buf[1]=0x69, ac=0x02.
- 0xC0 then 17 data bytes 0x41.. -> buf[16..31]=0x41..0x50, 17th byte not stored, ac=0x51.
- 0xCF then entry 0x04 then data 0x5A,0x5B -> buf[31]=0x5A, buf[30]=0x5B, ac=0x4D. Then rw=1 rs=0 read pair -> sf_d_out 4, D with sf_d_oe asserted.
- Clear followed immediately by data 0x41 -> byte dropped, overrun=1, buffer all 0x20.
